// File: rtl/i_fetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch queue.
// No ports: NOP default, request FSM states, fixed-width fetch entry.
package i_fetch_pkg;

  localparam logic [31:0] NOP_DEFAULT = 32'hF000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_BUBBLE
  } req_state_t;

  typedef struct packed {
    logic [19:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; push+pop allowed even when full.
// Ports: clk, rst_sync, push, pop, flush, din -> dout, full, empty, count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 52
) (
  input  logic                       clk,
  input  logic                       rst_sync,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/i_fetch_q.sv
// Instruction fetch: one outstanding mem read, DEPTH-entry prefetch, redirects.
// Ports: clk, rst_sync, fetch_en, mem_*, instruction/instr_pc/valid/ready, load_*.
module i_fetch_q
  import i_fetch_pkg::*;
#(
  parameter int                 ADDR_W        = 20,
  parameter int                 DATA_W        = 32,
  parameter int                 DEPTH         = 4,
  parameter int                 BUBBLE_CYCLES = 0,
  parameter logic [DATA_W-1:0]  NOP_INSTR     = DATA_W'(NOP_DEFAULT),
  parameter logic [ADDR_W-1:0]  RESET_PC      = '0
) (
  input  logic              clk,
  input  logic              rst_sync,
  input  logic              fetch_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_read_value,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              load_en,
  input  logic              load_offset,
  input  logic [ADDR_W-1:0] load_address
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  localparam int         CW  = $clog2(DEPTH) + 1;
  localparam logic [4:0] BUB = 5'(BUBBLE_CYCLES);
  localparam req_state_t ST0 = (BUBBLE_CYCLES == 0) ? S_IDLE : S_BUBBLE;

  req_state_t        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] last_pc;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] target;
  logic [4:0]        bub_cnt;
  logic              drop;
  logic              ack_fire;
  logic              pop_fire;
  logic              stale;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  entry_t            wr_entry;
  entry_t            head;

  assign ack_fire  = mem_req & mem_ack;
  assign pop_fire  = instr_valid & instr_ready;
  assign stale     = mem_req & ~mem_ack;
  // a pop in the redirect cycle is the instruction decode now executes
  assign base      = pop_fire ? instr_pc : last_pc;
  assign target    = load_offset ? base + load_address : load_address;
  assign fifo_push = ack_fire & ~drop & ~load_en;
  assign wr_entry  = '{pc: fetch_pc, instr: mem_read_value};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst_sync (rst_sync),
    .push     (fifo_push),
    .pop      (instr_ready),
    .flush    (load_en),
    .din      (wr_entry),
    .dout     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign instr_valid = (fifo_cnt != '0);
  assign instruction = fifo_empty ? NOP_INSTR : head.instr;
  assign instr_pc    = fifo_empty ? '0 : head.pc;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state       <= ST0;
      mem_req     <= 1'b0;
      mem_address <= RESET_PC;
      fetch_pc    <= RESET_PC;
      last_pc     <= RESET_PC;
      bub_cnt     <= '0;
      drop        <= 1'b0;
    end else begin
      if (pop_fire) last_pc <= instr_pc;
      if (ack_fire) begin
        mem_req <= 1'b0;
        drop    <= 1'b0;
      end
      if (load_en) begin
        fetch_pc <= target;
        bub_cnt  <= BUB;
        if (stale) drop <= 1'b1;
        state <= stale ? S_WAIT_ACK : S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (fetch_en && !fifo_full) begin
              mem_req     <= 1'b1;
              mem_address <= fetch_pc;
              state       <= S_WAIT_ACK;
            end
          end
          S_WAIT_ACK: begin
            if (ack_fire) begin
              if (!drop) fetch_pc <= fetch_pc + ADDR_W'(1);
              bub_cnt <= '0;
              state   <= ST0;
            end
          end
          S_BUBBLE: begin
            bub_cnt <= bub_cnt + 5'd1;
            if (bub_cnt + 5'd1 == BUB) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i_fetch_q.sv
// Directed bench for i_fetch_q: default instance plus a BUBBLE_CYCLES=4 one.
// Memory models ack one edge after mem_req and return address + 0x100.
module tb_i_fetch_q;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetch_en, mem_req, mem_ack, instr_valid, instr_ready;
  logic        load_en, load_offset;
  logic [19:0] mem_address, instr_pc, load_address;
  logic [31:0] mem_read_value, instruction;
  logic        ack_en, stray_ack;

  logic        b_rst, b_req, b_ack, b_valid;
  logic [19:0] b_addr, b_pc;
  logic [31:0] b_rdata, b_instr;

  int tests = 0;
  int fails = 0;

  i_fetch_q u_dut (
    .clk            (clk),
    .rst_sync       (rst),
    .fetch_en       (fetch_en),
    .mem_req        (mem_req),
    .mem_address    (mem_address),
    .mem_ack        (mem_ack),
    .mem_read_value (mem_read_value),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .load_en        (load_en),
    .load_offset    (load_offset),
    .load_address   (load_address)
  );

  i_fetch_q #(.BUBBLE_CYCLES(4)) u_bub (
    .clk            (clk),
    .rst_sync       (b_rst),
    .fetch_en       (1'b1),
    .mem_req        (b_req),
    .mem_address    (b_addr),
    .mem_ack        (b_ack),
    .mem_read_value (b_rdata),
    .instruction    (b_instr),
    .instr_pc       (b_pc),
    .instr_valid    (b_valid),
    .instr_ready    (1'b1),
    .load_en        (1'b0),
    .load_offset    (1'b0),
    .load_address   (20'h0)
  );

  initial begin
    mem_ack = 1'b0;
    mem_read_value = '0;
    forever begin
      @(negedge clk);
      mem_ack = (mem_req & ack_en) | stray_ack;
      mem_read_value = 32'(mem_address) + 32'h100;
    end
  end

  initial begin
    b_ack = 1'b0;
    b_rdata = '0;
    forever begin
      @(negedge clk);
      b_ack = b_req;
      b_rdata = 32'(b_addr) + 32'h100;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int rises;
    logic prev;
    int k;
    int last_ack;
    int nspace;
    int nbeat;

    rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
    load_en = 1'b0; load_offset = 1'b0; load_address = '0;
    ack_en = 1'b1; stray_ack = 1'b0; b_rst = 1'b1;
    step(); step();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instruction, 32'hF000_0000);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);

    // 1: streaming with ready held high
    rst = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
    step();
    chk("t1_req0", 32'(mem_req), 32'd1);
    chk("t1_addr0", 32'(mem_address), 32'd0);
    step();
    chk("t1_v0", 32'(instr_valid), 32'd1);
    chk("t1_i0", instruction, 32'h100);
    chk("t1_pc0", 32'(instr_pc), 32'd0);
    step();
    chk("t1_gap0", instruction, 32'hF000_0000);
    chk("t1_addr1", 32'(mem_address), 32'd1);
    step();
    chk("t1_i1", instruction, 32'h101);
    chk("t1_pc1", 32'(instr_pc), 32'd1);
    step();
    chk("t1_gap1", 32'(instr_valid), 32'd0);
    step();
    chk("t1_i2", instruction, 32'h102);
    chk("t1_pc2", 32'(instr_pc), 32'd2);

    // 2: stalled decode fills the FIFO, then drains in order
    rst = 1'b1; instr_ready = 1'b0;
    step();
    rst = 1'b0;
    rises = 0; prev = mem_req;
    for (int i = 0; i < 12; i++) begin
      step();
      if (mem_req && !prev) rises++;
      prev = mem_req;
    end
    chk("t2_reqs", 32'(rises), 32'd4);
    chk("t2_idle", 32'(mem_req), 32'd0);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_pc", 32'(instr_pc), 32'(i));
      chk("t2_drain_v", 32'(instr_valid), 32'd1);
      step();
    end
    chk("t2_resume_pc", 32'(instr_pc), 32'd4);
    chk("t2_resume_i", instruction, 32'h104);

    // 3: relative redirect with a request in flight
    for (int i = 0; i < 20 && !(instr_valid && instr_pc == 20'd5); i++)
      step();
    chk("t3_saw5", 32'(instr_valid && instr_pc == 20'd5), 32'd1);
    ack_en = 1'b0;
    step();
    chk("t3_req6", 32'(mem_req), 32'd1);
    chk("t3_addr6", 32'(mem_address), 32'd6);
    load_en = 1'b1; load_offset = 1'b1; load_address = 20'hFFFFD;
    step();
    load_en = 1'b0; ack_en = 1'b1;
    chk("t3_held", 32'(mem_req), 32'd1);
    step();
    chk("t3_dropped", 32'(instr_valid), 32'd0);
    step();
    chk("t3_addr2", 32'(mem_address), 32'd2);
    step();
    chk("t3_pc2", 32'(instr_pc), 32'd2);
    chk("t3_i2", instruction, 32'h102);

    // 4: absolute redirect and PC wrap
    load_en = 1'b1; load_offset = 1'b0; load_address = 20'hFFFFF;
    step();
    load_en = 1'b0;
    chk("t4_flush", 32'(instr_valid), 32'd0);
    step(); step();
    chk("t4_pcmax", 32'(instr_pc), 32'hFFFFF);
    chk("t4_imax", instruction, 32'h0010_00FF);
    step(); step();
    chk("t4_pcwrap", 32'(instr_pc), 32'd0);
    chk("t4_iwrap", instruction, 32'h100);

    // 6: reset during an outstanding request, stray ack right after
    ack_en = 1'b0;
    step();
    chk("t6_req1", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    chk("t6_rst_req", 32'(mem_req), 32'd0);
    rst = 1'b0; ack_en = 1'b1; stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    chk("t6_nopush", 32'(instr_valid), 32'd0);
    chk("t6_req", 32'(mem_req), 32'd1);
    chk("t6_addr", 32'(mem_address), 32'd0);
    step();
    chk("t6_v", 32'(instr_valid), 32'd1);
    chk("t6_pc", 32'(instr_pc), 32'd0);

    // 5: bubble spacing on the BUBBLE_CYCLES=4 instance
    b_rst = 1'b0;
    k = 0; last_ack = -1; nspace = 0; nbeat = 0; prev = b_req;
    for (int i = 0; i < 60; i++) begin
      step();
      k++;
      if (b_ack) last_ack = k;
      if (b_req && !prev && last_ack >= 0 && nspace < 3) begin
        chk("t5_space", 32'(k - last_ack), 32'd5);
        nspace++;
      end
      if (b_valid && nbeat < 3) begin
        chk("t5_pc", 32'(b_pc), 32'(nbeat));
        chk("t5_instr", b_instr, 32'(nbeat) + 32'h100);
        nbeat++;
      end
      prev = b_req;
    end
    chk("t5_nspace", 32'(nspace), 32'd3);
    chk("t5_nbeat", 32'(nbeat), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
